iop_channel_scheduler: RTL

Sequencing and sharing controller for one IOP. Sits between the CPU I/O instruction path and that IOP's device controllers. Executes SIO/TIO/TDV/HIO/AIO commands against a per-device busy/interrupt table, starts and stops device controllers via per-device `dev_active` lines, and arbitrates the single IOP memory port among running devices.

---
 rtl/iop_channel_scheduler.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/iop_channel_scheduler.sv
// rtl/iop_channel_scheduler.sv - IOP command sequencer, device busy/interrupt table and memory-port arbiter
//
// Executes SIO/TIO/TDV/HIO/AIO against a per-device busy/interrupt table,
// drives per-device run enables and shares the single IOP memory port
// round-robin with a bounded burst length.
//
// Ports:
//   clock, reset              system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (accepted in IDLE only)
//   cmd_func, cmd_device      function code; {IOP[10:8], device[7:0]}
//   cmd_done, cmd_cc          one-cycle completion pulse with condition code
//   aio_device                device reported by AIO (0 otherwise)
//   dev_active                run enable per device (mirrors busy table)
//   dev_done                  device finished (honoured only while busy)
//   dev_req, mem_grant        memory-port request / one-hot registered grant
module iop_channel_scheduler #(
    parameter int NUM_DEV   = 8,
    parameter int IOP_NUM   = 0,
    parameter int MAX_BURST = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_func,
    input  logic [10:0]        cmd_device,
    output logic               cmd_ready,
    output logic               cmd_done,
    output logic [1:0]         cmd_cc,
    output logic [7:0]         aio_device,
    output logic [NUM_DEV-1:0] dev_active,
    input  logic [NUM_DEV-1:0] dev_done,
    input  logic [NUM_DEV-1:0] dev_req,
    output logic [NUM_DEV-1:0] mem_grant
);
    localparam int IW = $clog2(NUM_DEV);

    localparam logic [2:0] F_SIO = 3'd0;
    localparam logic [2:0] F_TIO = 3'd1;
    localparam logic [2:0] F_TDV = 3'd2;
    localparam logic [2:0] F_HIO = 3'd3;
    localparam logic [2:0] F_AIO = 3'd6;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    localparam logic [3:0] BURST_SAT   = 4'hF;

    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_RESPOND} state_t;

    state_t             state_q;
    logic               cmd_ready_q;
    logic               cmd_done_q;
    logic [1:0]         cc_q;
    logic [7:0]         aio_q;
    logic [2:0]         func_q;
    logic [2:0]         iop_q;
    logic [7:0]         dev_q;

    logic [NUM_DEV-1:0] busy_q, busy_d;
    logic [NUM_DEV-1:0] int_q, int_d;
    logic [NUM_DEV-1:0] grant_q, grant_d;
    logic [IW-1:0]      last_q, last_d;
    logic [3:0]         burst_q, burst_d;

    // ------------------------------------------------------------------
    // Command evaluation (only meaningful while in DECODE)
    // ------------------------------------------------------------------
    logic               iop_ok, dev_ok, sel_busy;
    logic [IW-1:0]      dev_idx;
    logic               aio_found;
    logic [IW-1:0]      aio_idx;
    logic [1:0]         cc_d;
    logic [7:0]         aio_d;
    logic [NUM_DEV-1:0] sio_set, hio_clr, aio_clr, done_eff;

    assign iop_ok   = (iop_q == 3'(IOP_NUM));
    assign dev_ok   = (int'(dev_q) < NUM_DEV);
    assign dev_idx  = dev_q[IW-1:0];
    assign sel_busy = busy_q[dev_idx];

    // Lowest-numbered pending interrupt: scan downward so the last hit wins.
    always_comb begin
        aio_found = 1'b0;
        aio_idx   = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (int_q[i]) begin
                aio_found = 1'b1;
                aio_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        cc_d    = 2'b11;
        aio_d   = 8'd0;
        sio_set = '0;
        hio_clr = '0;
        aio_clr = '0;
        if (state_q == ST_DECODE) begin
            case (func_q)
                F_SIO: begin
                    if (iop_ok && dev_ok) begin
                        cc_d             = {1'b0, sel_busy};
                        sio_set[dev_idx] = !sel_busy;
                    end
                end
                F_TIO, F_TDV: begin
                    if (iop_ok && dev_ok) begin
                        cc_d = {1'b0, sel_busy};
                    end
                end
                F_HIO: begin
                    if (iop_ok && dev_ok) begin
                        cc_d             = {1'b0, sel_busy};
                        hio_clr[dev_idx] = sel_busy;
                    end
                end
                F_AIO: begin
                    if (iop_ok && aio_found) begin
                        cc_d             = 2'b00;
                        aio_d            = 8'(aio_idx);
                        aio_clr[aio_idx] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A completion only counts on a busy device. HIO on the same edge wins:
    // the device stops without raising an interrupt. A fresh completion is
    // applied after an AIO acknowledge so it is never lost.
    assign done_eff = dev_done & busy_q;
    assign busy_d   = (busy_q & ~done_eff & ~hio_clr) | sio_set;
    assign int_d    = (int_q & ~aio_clr) | (done_eff & ~hio_clr);

    // ------------------------------------------------------------------
    // Memory-port arbiter
    // ------------------------------------------------------------------
    logic [NUM_DEV-1:0] cand, others;
    logic               holder_ok, rotate, pick_found;
    logic [IW-1:0]      pick_idx, scan_idx;

    assign cand      = busy_q & dev_req;
    assign others    = cand & ~grant_q;
    assign holder_ok = |(grant_q & cand);
    assign rotate    = holder_ok && (burst_q >= BURST_LIMIT) && (|others);

    // Search starts just after the last granted device; the current holder
    // is excluded so a rotation always moves to someone else.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_DEV; k++) begin
            scan_idx = IW'((int'(last_q) + k) % NUM_DEV);
            if (!pick_found && others[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        grant_d = grant_q;
        burst_d = burst_q;
        last_d  = last_q;
        if (holder_ok && !rotate) begin
            burst_d = (burst_q == BURST_SAT) ? burst_q : burst_q + 4'd1;
        end else if (pick_found) begin
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            last_d            = pick_idx;
            burst_d           = 4'd1;
        end else begin
            grant_d = '0;
            burst_d = 4'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            int_q   <= '0;
            grant_q <= '0;
            last_q  <= '0;
            burst_q <= 4'd0;
        end else begin
            busy_q  <= busy_d;
            int_q   <= int_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            cmd_done_q  <= 1'b0;
            cc_q        <= 2'b00;
            aio_q       <= 8'd0;
            func_q      <= 3'd0;
            iop_q       <= 3'd0;
            dev_q       <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        func_q      <= cmd_func;
                        iop_q       <= cmd_device[10:8];
                        dev_q       <= cmd_device[7:0];
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    cc_q       <= cc_d;
                    aio_q      <= aio_d;
                    cmd_done_q <= 1'b1;
                    state_q    <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    cmd_done_q  <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign cmd_done   = cmd_done_q;
    assign cmd_cc     = cc_q;
    assign aio_device = aio_q;
    assign dev_active = busy_q;
    assign mem_grant  = grant_q;

endmodule
